// File: rtl/fixed_point_pkg.sv
// Shared Q8.8 sign-magnitude constants and types for the fixed-point math blocks.
package fixed_point_pkg;

    localparam int FXP_WIDTH = 16;
    localparam int FXP_FRAC  = 8;
    localparam int FXP_MAG_W = FXP_WIDTH - 1;
    localparam int FXP_NUM_W = FXP_MAG_W + FXP_FRAC;

    typedef logic [FXP_WIDTH-1:0] fxp_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/fixed_point_divider_step.sv
// One combinational restoring-division step: shift a numerator bit in, subtract the divisor if it fits.
module fixed_point_div_step #(
    parameter int MAG_W = 15
) (
    input  logic [MAG_W:0]   rem,
    input  logic             next_bit,
    input  logic [MAG_W-1:0] den,
    output logic [MAG_W:0]   rem_next,
    output logic             q_bit
);

    logic [MAG_W+1:0] trial;

    always_comb begin
        trial    = {rem, next_bit};
        q_bit    = (trial >= {2'b00, den});
        rem_next = q_bit ? (MAG_W+1)'(trial - {2'b00, den}) : trial[MAG_W:0];
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential Q8.8 sign-magnitude restoring divider, one quotient bit per clock.
// Define FIXED_POINT_DIVIDER_ROUND_EN for one extra guard iteration and round-half-away magnitude.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int FRAC  = FXP_FRAC
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int MAG_W = WIDTH - 1;
    localparam int NUM_W = MAG_W + FRAC;
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    localparam int ITERS = NUM_W + 1;
`else
    localparam int ITERS = NUM_W;
`endif
    localparam int CNT_W = $clog2(ITERS);

    div_state_t       state_reg;
    logic [NUM_W-1:0] num_reg;
    logic [MAG_W-1:0] den_reg;
    logic [MAG_W:0]   rem_reg;
    logic [ITERS-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sign_reg;
    logic             dz_reg;

    logic [MAG_W:0]   rem_next;
    logic             q_bit;

    logic [NUM_W-1:0] trunc;
    logic [MAG_W:0]   sum;
    logic [MAG_W-1:0] res_mag;
    logic             res_ovf;
    logic             res_sign;

    fixed_point_div_step #(.MAG_W(MAG_W)) u_step (
        .rem      (rem_reg),
        .next_bit (num_reg[NUM_W-1]),
        .den      (den_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // With rounding the accumulator carries one extra LSB: the guard bit below the truncated result.
    always_comb begin
        trunc = acc_reg[ITERS-1 -: NUM_W];
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
        sum = {1'b0, trunc[MAG_W-1:0]} + {{MAG_W{1'b0}}, acc_reg[0]};
`else
        sum = {1'b0, trunc[MAG_W-1:0]};
`endif
        res_ovf = (|trunc[NUM_W-1:MAG_W]) | sum[MAG_W];
        res_mag = res_ovf ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
        if (dz_reg) begin
            res_ovf = 1'b0;
            res_mag = {MAG_W{1'b1}};
        end
        res_sign = sign_reg & (res_mag != '0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            num_reg     <= '0;
            den_reg     <= '0;
            rem_reg     <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            sign_reg    <= 1'b0;
            dz_reg      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        num_reg   <= {dividend[MAG_W-1:0], {FRAC{1'b0}}};
                        den_reg   <= divisor[MAG_W-1:0];
                        sign_reg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dz_reg    <= (divisor[MAG_W-1:0] == '0);
                        rem_reg   <= '0;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    acc_reg <= {acc_reg[ITERS-2:0], q_bit};
                    num_reg <= {num_reg[NUM_W-2:0], 1'b0};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(ITERS - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    quotient    <= {res_sign, res_mag};
                    overflow    <= res_ovf;
                    div_by_zero <= dz_reg;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Randomised and directed check of fixed_point_divider against an arithmetic reference model.
module tb_fixed_point_divider;
    import fixed_point_pkg::*;

`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    localparam int LAT = 25;
`else
    localparam int LAT = 24;
`endif

    logic clk = 1'b0;
    logic n_rst;
    logic start;
    fxp_t dividend;
    fxp_t divisor;
    logic busy;
    logic done;
    fxp_t quotient;
    logic overflow;
    logic div_by_zero;

    int errors = 0;
    int checks = 0;

    fixed_point_divider dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer division of the scaled magnitudes, then saturation and sign rules.
    task automatic model(input fxp_t a, input fxp_t b, output fxp_t q, output logic ovf, output logic dz);
        int unsigned ma, mb, t;
        logic s;
        ma = 32'(a[14:0]);
        mb = 32'(b[14:0]);
        s  = a[15] ^ b[15];
        if (mb == 0) begin
            q   = {s, 15'h7FFF};
            ovf = 1'b0;
            dz  = 1'b1;
        end else begin
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
            t = (ma << 9) / mb;
            t = (t >> 1) + (t & 1);
`else
            t = (ma << 8) / mb;
`endif
            dz  = 1'b0;
            ovf = (t > 32'h7FFF);
            if (ovf) t = 32'h7FFF;
            if (t == 0) s = 1'b0;
            q = {s, t[14:0]};
        end
    endtask

    task automatic run_div(input fxp_t a, input fxp_t b, input logic hold,
                           input fxp_t exp_q, input logic exp_ovf, input logic exp_dz);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        dividend = fxp_t'($urandom);
        divisor  = fxp_t'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(LAT));
        check("quotient", 32'(quotient), 32'(exp_q));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
        check("busy_at_done", 32'(busy), 32'd0);
        $display("div 0x%04h / 0x%04h -> q=0x%04h ovf=%0b dz=%0b lat=%0d",
                 a, b, quotient, overflow, div_by_zero, lat);
        @(posedge clk);
        #1;
        check("done_single_pulse", 32'(done), 32'd0);
        check("quotient_held", 32'(quotient), 32'(exp_q));
    endtask

    task automatic run_model(input fxp_t a, input fxp_t b);
        fxp_t q;
        logic ovf, dz;
        model(a, b, q, ovf, dz);
        run_div(a, b, 1'b0, q, ovf, dz);
    endtask

    initial begin
        fxp_t a, b, qd;
        int ndone;

        n_rst    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Held start also probes that the DONE cycle does not accept a new request.
        run_div(16'h00C0, 16'h0080, 1'b1, 16'h0180, 1'b0, 1'b0);
        run_div(16'h8900, 16'h0300, 1'b0, 16'h8300, 1'b0, 1'b0);
        run_div(16'h8000, 16'h0300, 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
        run_div(16'h0200, 16'h0300, 1'b0, 16'h00AB, 1'b0, 1'b0);
`else
        run_div(16'h0200, 16'h0300, 1'b0, 16'h00AA, 1'b0, 1'b0);
`endif
        run_div(16'h7F00, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0);
        run_div(16'h8100, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = fxp_t'($urandom);
            b[14:0] = 15'($urandom_range(0, 32'h7FFF) >> $urandom_range(0, 14));
            b[15]   = 1'($urandom);
            if (b[14:0] == '0) begin
                b[15]   = 1'b0;
                a[14:0] = a[14:0] | 15'h1;
            end
            run_model(a, b);
        end

        // A second start while busy must be neither restarted nor queued.
        @(negedge clk);
        dividend = 16'h0300;
        divisor  = 16'h0100;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'h0100;
        divisor  = 16'h0100;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        qd    = '0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                qd = quotient;
            end
        end
        check("busy_start_done_count", 32'(ndone), 32'd1);
        check("busy_start_quotient", 32'(qd), 32'h0300);
        $display("busy-start 0x0300 / 0x0100 -> q=0x%04h dones=%0d", qd, ndone);

        // Reset on the 10th CALC cycle aborts the division.
        @(negedge clk);
        dividend = 16'h0500;
        divisor  = 16'h0100;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        $display("abort 0x0500 / 0x0100 -> dones after release=%0d", ndone);
        run_div(16'h0100, 16'h0200, 1'b0, 16'h0080, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
